// File: rtl/ps2_scan_receiver_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Keyboard status/response bytes that never represent a key.
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Pin-side and key-event signals of the PS/2 receiver, plus its FSM state for observation.
interface ps2_scan_receiver_if;
    import ps2_pkg::*;

    logic       kb_clock;
    logic       kb_data;
    logic [7:0] raw_data;
    logic       code_valid;
    logic       key_down;
    logic       extended;
    logic       frame_error;
    ps2_state_t state;

    // code_valid is a one-cycle strobe with no back-pressure (no ready): key_down and
    // extended are meaningful in that cycle and hold until the next strobe; raw_data
    // is a level that always reflects the currently held make code.
    modport master (
        output kb_clock, kb_data,
        input  raw_data, code_valid, key_down, extended, frame_error, state
    );

    modport slave (
        input  kb_clock, kb_data,
        output raw_data, code_valid, key_down, extended, frame_error, state
    );

endinterface

// File: rtl/ps2_scan_receiver_sync_edge.sv
// Two-flop synchronisers for the PS/2 pins and a falling-edge detector on kb_clock.
module ps2_sync_edge (
    input  logic clock,
    input  logic resetn,
    input  logic kb_clock,
    input  logic kb_data,
    output logic data_sync,
    output logic fall_pulse
);

    // Bits [1:0] form the synchroniser, bit [2] is the previous synchronised value.
    // Reset to 1 (idle bus level) so leaving reset never fakes an edge.
    logic [2:0] clk_sr;
    logic [1:0] dat_sr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sr <= 3'b111;
            dat_sr <= 2'b11;
        end else begin
            clk_sr <= {clk_sr[1:0], kb_clock};
            dat_sr <= {dat_sr[0], kb_data};
        end
    end

    assign data_sync  = dat_sr[1];
    assign fall_pulse = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 frame receiver: deserialises frames, resolves F0/E0 prefixes, tracks the held make code.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic               clock,
    input logic               resetn,
    ps2_scan_receiver_if.slave bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    logic data_sync;
    logic fall_pulse;

    ps2_sync_edge u_sync (
        .clock      (clock),
        .resetn     (resetn),
        .kb_clock   (bus.kb_clock),
        .kb_data    (bus.kb_data),
        .data_sync  (data_sync),
        .fall_pulse (fall_pulse)
    );

    ps2_state_t    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic          stop_bit;
    logic          frame_done;
    logic [CW-1:0] tcnt;
    logic          break_pending;
    logic          ext_pending;
    logic [7:0]    raw_data;
    logic          code_valid;
    logic          key_down;
    logic          extended;
    logic          frame_error;
    logic          frame_good;

    assign frame_good = stop_bit & (^{shift, parity_bit});

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            bitcnt        <= '0;
            shift         <= '0;
            parity_bit    <= 1'b0;
            stop_bit      <= 1'b0;
            frame_done    <= 1'b0;
            tcnt          <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            raw_data      <= '0;
            code_valid    <= 1'b0;
            key_down      <= 1'b0;
            extended      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            frame_done  <= 1'b0;

            if (state == IDLE) begin
                tcnt <= '0;
                // A sampled 1 here is a glitch, not a start bit: ignore it silently.
                if (fall_pulse && !data_sync) begin
                    state  <= DATA;
                    bitcnt <= '0;
                end
            end else if (fall_pulse) begin
                tcnt <= '0;
                case (state)
                    DATA: begin
                        shift[bitcnt] <= data_sync;
                        if (bitcnt == 3'd7) state <= PARITY;
                        else                bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY: begin
                        parity_bit <= data_sync;
                        state      <= STOP;
                    end
                    default: begin
                        stop_bit   <= data_sync;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                endcase
            end else if (tcnt == TLAST) begin
                state         <= IDLE;
                tcnt          <= '0;
                frame_error   <= 1'b1;
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
            end else begin
                tcnt <= tcnt + CW'(1);
            end

            // Byte decode runs one cycle after the stop edge, always from IDLE.
            if (frame_done) begin
                if (!frame_good) begin
                    frame_error   <= 1'b1;
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else if (shift == PS2_BREAK) begin
                    break_pending <= 1'b1;
                end else if (shift == PS2_EXT) begin
                    ext_pending <= 1'b1;
                end else if (is_status(shift)) begin
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else begin
                    code_valid    <= 1'b1;
                    key_down      <= !break_pending;
                    extended      <= ext_pending;
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                    // A break only clears raw_data when it releases the key being held.
                    if (!break_pending)       raw_data <= shift;
                    else if (raw_data == shift) raw_data <= 8'h00;
                end
            end
        end
    end

    assign bus.raw_data    = raw_data;
    assign bus.code_valid  = code_valid;
    assign bus.key_down    = key_down;
    assign bus.extended    = extended;
    assign bus.frame_error = frame_error;
    assign bus.state       = state;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: PS/2 frames driven on the pins, events checked per scenario.
module tb_ps2_scan_receiver;
    import ps2_pkg::*;

    localparam int TIMEOUT = 200;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observed events: {key_down, extended, raw_data} and their cycle stamps.
    logic [9:0] obs_q[$];
    int         obs_cyc[$];
    logic [9:0] exp_q[$];
    int         err_count = 0;
    int         err_cyc   = 0;
    int         fall_cyc  = 0;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (bus.code_valid) begin
            obs_q.push_back({bus.key_down, bus.extended, bus.raw_data});
            obs_cyc.push_back(cyc);
        end
        if (bus.frame_error) begin
            err_count++;
            err_cyc = cyc;
        end
    end

    // ---------------- drivers ----------------
    task automatic ps2_bit(input logic v);
        @(posedge clock); #1;
        bus.kb_data = v;
        repeat (5) @(posedge clock); #1;
        bus.kb_clock = 1'b0;
        fall_cyc = cyc;
        repeat (10) @(posedge clock); #1;
        bus.kb_clock = 1'b1;
        repeat (5) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [PS2_FRAME_BITS-1:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < PS2_FRAME_BITS; i++) ps2_bit(f[i]);
        repeat (10) @(posedge clock);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++; if (bus.raw_data !== 8'h00) begin errors++; $display("FAIL reset_raw actual=%h required=00", bus.raw_data); end
        checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL reset_cv actual=%b required=0", bus.code_valid); end
        checks++; if (bus.key_down !== 1'b0) begin errors++; $display("FAIL reset_kd actual=%b required=0", bus.key_down); end
        checks++; if (bus.extended !== 1'b0) begin errors++; $display("FAIL reset_ext actual=%b required=0", bus.extended); end
        checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr actual=%b required=0", bus.frame_error); end
        checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state actual=%0d required=%0d", bus.state, IDLE); end
    endtask

    task automatic test_make();
        clear_obs();
        exp_q.push_back({1'b1, 1'b0, 8'h1C});
        send_frame(8'h1C, 1'b0);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL make_count actual=%0d required=1", obs_q.size()); end
        checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL make_event actual=%h required=%h", obs_q[0], exp_q[0]); end
        checks++; if (obs_cyc[0] - fall_cyc != 4) begin errors++; $display("FAIL make_latency actual=%0d required=4", obs_cyc[0] - fall_cyc); end
        checks++; if (bus.raw_data !== 8'h1C) begin errors++; $display("FAIL make_raw actual=%h required=1c", bus.raw_data); end
    endtask

    task automatic test_typematic();
        clear_obs();
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL typematic_count actual=%0d required=2", obs_q.size()); end
        checks++; if (obs_q[1] !== {1'b1, 1'b0, 8'h1C}) begin errors++; $display("FAIL typematic_event actual=%h required=21c", obs_q[1]); end
    endtask

    task automatic test_break();
        clear_obs();
        send_frame(PS2_BREAK, 1'b0);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL break_prefix_silent actual=%0d required=0", obs_q.size()); end
        send_frame(8'h1C, 1'b0);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL break_count actual=%0d required=1", obs_q.size()); end
        checks++; if (obs_q[0] !== {1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL break_event actual=%h required=000", obs_q[0]); end
        checks++; if (bus.raw_data !== 8'h00) begin errors++; $display("FAIL break_raw actual=%h required=00", bus.raw_data); end
    endtask

    task automatic test_two_keys();
        clear_obs();
        exp_q.push_back({1'b1, 1'b0, 8'h1C});
        exp_q.push_back({1'b1, 1'b0, 8'h23});
        exp_q.push_back({1'b0, 1'b0, 8'h23});
        send_frame(8'h1C, 1'b0);
        send_frame(8'h23, 1'b0);
        send_frame(PS2_BREAK, 1'b0);
        send_frame(8'h1C, 1'b0);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL two_keys_count actual=%0d required=3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_keys_event%0d actual=%h required=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.raw_data !== 8'h23) begin errors++; $display("FAIL two_keys_raw actual=%h required=23", bus.raw_data); end
    endtask

    task automatic test_parity_error();
        int e0;
        clear_obs();
        e0 = err_count;
        send_frame(8'h2B, 1'b1);
        checks++; if (err_count != e0 + 1) begin errors++; $display("FAIL parity_err_pulses actual=%0d required=1", err_count - e0); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL parity_no_cv actual=%0d required=0", obs_q.size()); end
        checks++; if (bus.raw_data !== 8'h23) begin errors++; $display("FAIL parity_raw_kept actual=%h required=23", bus.raw_data); end
        send_frame(8'h2B, 1'b0);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL parity_recover_count actual=%0d required=1", obs_q.size()); end
        checks++; if (bus.raw_data !== 8'h2B) begin errors++; $display("FAIL parity_recover_raw actual=%h required=2b", bus.raw_data); end
    endtask

    task automatic test_timeout();
        int e0;
        int start;
        clear_obs();
        e0 = err_count;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        start = fall_cyc;
        for (int k = 0; k < TIMEOUT + 50 && err_count == e0; k++) @(posedge clock);
        #1;
        checks++; if (err_count != e0 + 1) begin errors++; $display("FAIL timeout_pulse actual=%0d required=1", err_count - e0); end
        // Measured from the pin edge: three synchroniser cycles, then the full timeout.
        checks++; if (err_cyc - start != TIMEOUT + 3) begin errors++; $display("FAIL timeout_latency actual=%0d required=%0d", err_cyc - start, TIMEOUT + 3); end
        checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL timeout_state actual=%0d required=%0d", bus.state, IDLE); end
        send_frame(8'h24, 1'b0);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL timeout_recover_count actual=%0d required=1", obs_q.size()); end
        checks++; if (bus.raw_data !== 8'h24) begin errors++; $display("FAIL timeout_recover_raw actual=%h required=24", bus.raw_data); end
    endtask

    task automatic test_status();
        int e0;
        clear_obs();
        e0 = err_count;
        ps2_bit(1'b1);
        send_frame(PS2_EXT, 1'b0);
        send_frame(PS2_BAT_OK, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++; if (err_count != e0) begin errors++; $display("FAIL status_no_error actual=%0d required=0", err_count - e0); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL status_count actual=%0d required=1", obs_q.size()); end
        checks++; if (obs_q[0] !== {1'b1, 1'b0, 8'h75}) begin errors++; $display("FAIL status_clears_ext actual=%h required=275", obs_q[0]); end
    endtask

    task automatic test_extended_reset();
        clear_obs();
        send_frame(PS2_EXT, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL ext_count actual=%0d required=1", obs_q.size()); end
        checks++; if (obs_q[0] !== {1'b1, 1'b1, 8'h75}) begin errors++; $display("FAIL ext_event actual=%h required=375", obs_q[0]); end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        checks++; if (bus.raw_data !== 8'h00) begin errors++; $display("FAIL midreset_raw actual=%h required=00", bus.raw_data); end
        checks++; if (bus.key_down !== 1'b0) begin errors++; $display("FAIL midreset_kd actual=%b required=0", bus.key_down); end
        checks++; if (bus.extended !== 1'b0) begin errors++; $display("FAIL midreset_ext actual=%b required=0", bus.extended); end
        checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL midreset_state actual=%0d required=%0d", bus.state, IDLE); end
        repeat (3) @(posedge clock); #1;
        resetn = 1'b1;
        clear_obs();
        send_frame(8'h15, 1'b0);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL postreset_count actual=%0d required=1", obs_q.size()); end
        checks++; if (obs_q[0] !== {1'b1, 1'b0, 8'h15}) begin errors++; $display("FAIL postreset_event actual=%h required=215", obs_q[0]); end
        checks++; if (bus.raw_data !== 8'h15) begin errors++; $display("FAIL postreset_raw actual=%h required=15", bus.raw_data); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.kb_clock = 1'b1;
        bus.kb_data  = 1'b1;
        resetn       = 1'b0;
        repeat (3) @(posedge clock);
        test_reset();
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (5) @(posedge clock);
        test_make();
        test_typematic();
        test_break();
        test_two_keys();
        test_parity_error();
        test_timeout();
        test_status();
        test_extended_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Upstream stage of the keyboard path: deserialises PS/2 frames from kb_clock/kb_data into scan-code bytes.
- Resolves the 0xF0 break prefix and the 0xE0 extended prefix.
- Holds the currently pressed key's make code on raw_data for the combinational scan-code-to-ASCII converter.
- Everything runs in the system clock domain; the PS/2 pins are treated as asynchronous inputs.

Parameters:
- TIMEOUT_CYCLES, 50000, system clocks with no kb_clock falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- kb_clock  input  1  PS/2 clock pin, asynchronous.
- kb_data  input  1  PS/2 data pin, asynchronous.
- raw_data  output  8  make code of the held key; 0x00 when no key is held.
- code_valid  output  1  one-cycle pulse for each accepted key event.
- key_down  output  1  valid with code_valid: 1 = make, 0 = break.
- extended  output  1  valid with code_valid: the event was preceded by 0xE0.
- frame_error  output  1  one-cycle pulse on a parity error, stop-bit error, or timeout.

Behaviour:
- Interface: one clock, clock; reset resetn is asynchronous and active-low.
- Reset: raw_data=0x00, code_valid=0, key_down=0, extended=0, frame_error=0. FSM goes to IDLE; shift register, bit counter, timeout counter and pending flags clear. Asserting reset mid-frame discards the partial frame; the next frame is received normally.
- Synchronisation: kb_clock and kb_data each pass through a 2-FF synchroniser. A falling edge is prev_sync=1, sync=0. It is detected 3 cycles after the pin edge; kb_data_sync is sampled in the same cycle.
- Frame format: 11 bits, LSB-first data. Start=0, d0..d7, odd parity, stop=1.
- FSM states IDLE, DATA, PARITY, STOP. All transitions occur only on a detected falling edge, except timeout.
  - IDLE: sample 0 goes to DATA with bitcnt=0. Sample 1 stays in IDLE; this is a glitch and raises no error.
  - DATA: shift the sample into bit[bitcnt]. At bitcnt=7 go to PARITY; otherwise bitcnt+1.
  - PARITY: store the parity bit, go to STOP.
  - STOP: go to IDLE. The frame is good when stop=1 and (XOR of d0..d7 and parity)=1.
- Timeout:
  - The counter clears on every detected falling edge and is held at 0 in IDLE.
  - In any other state it increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear the pending flags.
- Byte handling, registered in the cycle after the STOP edge:
  - Bad frame: pulse frame_error, clear break_pending and ext_pending. No code_valid; raw_data unchanged.
  - 0xF0: set break_pending; no output.
  - 0xE0: set ext_pending; no output.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: status bytes. Dropped; pending flags cleared.
  - Any other byte b:
    - pulse code_valid; key_down = !break_pending; extended = ext_pending.
    - Clear both pending flags.
    - Make: raw_data <= b.
    - Break: raw_data <= 0x00 only if raw_data==b; otherwise raw_data is unchanged.
- Latency: code_valid is high exactly one cycle, 4 cycles after the pin-level stop-bit falling edge. key_down and extended hold their values until the next code_valid.
- Typematic repeat (same make code again): each repeat produces a code_valid pulse; raw_data is unchanged.
- A prefix followed by a bad frame or timeout is discarded entirely.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - status-byte constants;
  - the state enum IDLE/DATA/PARITY/STOP;
  - frame length 11.
- Sub-module ps2_sync_edge: 2-FF synchronisers for both pins plus the kb_clock falling-edge detector. Outputs data_sync and fall_pulse; reset is async active-low.

Test Plan:
- Valid frame 0x1C (parity 0) -> one code_valid pulse 4 cycles after the stop edge; key_down=1, extended=0, raw_data=0x1C.
- Frames F0,1C after a 0x1C make -> exactly one code_valid, key_down=0, raw_data=0x00. The F0 byte alone produces no pulse.
- Make 0x1C, make 0x23, then break F0,1C -> raw_data=0x23 after the break; three code_valid pulses total.
- Frame 0x2B with parity bit flipped -> frame_error one cycle, no code_valid, raw_data unchanged. A following good 0x2B is accepted.
- Start bit plus 4 data bits then idle -> frame_error exactly TIMEOUT_CYCLES cycles after the last edge (set TIMEOUT_CYCLES=200). A subsequent 0x24 frame is accepted with raw_data=0x24.
- E0,75 -> code_valid with extended=1, key_down=1. Then resetn pulsed low mid-frame -> all outputs 0 immediately; a subsequent 0x15 frame gives raw_data=0x15, extended=0.
